// File: rtl/trap_csr_unit.sv
// Trap-entry / trap-return sequencer: resolves interrupts and exceptions, applies M/S delegation,
// maintains the trap CSRs and privilege mode, and issues a registered PC redirect.
module trap_csr_unit #(
    parameter int                XLEN      = 64,
    parameter int                EXC_W     = 16,
    parameter logic [XLEN-1:0]   MTVEC_RST = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [EXC_W-1:0]  exc_vec_i,
    input  logic [11:0]       intr_vec_i,
    input  logic              mret_i,
    input  logic              sret_i,
    input  logic              csr_wen_i,
    input  logic [11:0]       csr_addr_i,
    input  logic [XLEN-1:0]   csr_wdata_i,
    output logic [1:0]        priv_mode_o,
    output logic [XLEN-1:0]   mstatus_o,
    output logic [XLEN-1:0]   mepc_o,
    output logic [XLEN-1:0]   mcause_o,
    output logic [XLEN-1:0]   sepc_o,
    output logic [XLEN-1:0]   scause_o,
    output logic [XLEN-1:0]   mtvec_o,
    output logic [XLEN-1:0]   stvec_o,
    output logic [XLEN-1:0]   medeleg_o,
    output logic [XLEN-1:0]   mideleg_o,
    output logic              raise_trap_o,
    output logic              raise_intr_o,
    output logic [XLEN-1:0]   cause_no_o,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_target_o
);

    if (XLEN != 64) begin : g_xlen_chk
        $error("trap_csr_unit: only XLEN=64 is supported");
    end
    if (EXC_W < 16) begin : g_excw_chk
        $error("trap_csr_unit: EXC_W must be at least 16");
    end

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam int MS_SIE  = 1;
    localparam int MS_MIE  = 3;
    localparam int MS_SPIE = 5;
    localparam int MS_MPIE = 7;
    localparam int MS_SPP  = 8;
    localparam int MS_TSR  = 22;
    localparam logic [63:0] MS_WMASK = 64'h0000_0000_007E_19AA;
    localparam logic [63:0] MS_XL    = 64'h0000_000A_0000_0000;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MEDELEG = 12'h302;
    localparam logic [11:0] A_MIDELEG = 12'h303;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_STVEC   = 12'h105;
    localparam logic [11:0] A_SEPC    = 12'h141;
    localparam logic [11:0] A_SCAUSE  = 12'h142;

    // Highest priority first; causes missing from these lists are never taken.
    localparam int N_IRQ = 6;
    localparam int IRQ_PRIO [N_IRQ] = '{11, 3, 7, 9, 1, 5};
    localparam int N_EXC = 13;
    localparam int EXC_PRIO [N_EXC] = '{3, 12, 1, 2, 8, 9, 11, 6, 4, 15, 13, 7, 5};

    logic [1:0]      priv_q, priv_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
    logic [XLEN-1:0] sepc_q, sepc_d, scause_q, scause_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, stvec_q, stvec_d;
    logic [XLEN-1:0] medeleg_q, medeleg_d, mideleg_q, mideleg_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_target_q, redirect_target_d;

    logic            do_mret, do_sret, ret_illegal, ret_m, ret_s;
    logic [15:0]     exc_all;
    logic            exc_hit, irq_hit, take_trap, take_intr, to_s;
    logic            irq_s_ok, irq_m_ok;
    logic [11:0]     irq_en;
    logic [3:0]      exc_cause, irq_cause, cause;
    logic [XLEN-1:0] tvec, trap_target, cause_word, ms_wr;
    logic            unused_bits;

    assign unused_bits = ^{exc_vec_i[0], exc_vec_i[10], exc_vec_i[14],
                           irq_en[0], irq_en[2], irq_en[4], irq_en[6], irq_en[8], irq_en[10]};

    always_comb begin
        do_mret     = inst_valid_i & mret_i;
        do_sret     = inst_valid_i & sret_i & ~mret_i;
        ret_illegal = (do_mret & (priv_q != PRIV_M)) |
                      (do_sret & ((priv_q == PRIV_U) | ((priv_q == PRIV_S) & mstatus_q[MS_TSR])));
        exc_all     = exc_vec_i[15:0] | {13'b0, ret_illegal, 2'b00};

        exc_hit   = 1'b0;
        exc_cause = 4'd0;
        for (int k = N_EXC - 1; k >= 0; k--) begin
            if (exc_all[EXC_PRIO[k]]) begin
                exc_hit   = 1'b1;
                exc_cause = 4'(EXC_PRIO[k]);
            end
        end

        irq_s_ok = (priv_q == PRIV_U) | ((priv_q == PRIV_S) & mstatus_q[MS_SIE]);
        irq_m_ok = (priv_q != PRIV_M) | mstatus_q[MS_MIE];
        for (int i = 0; i < 12; i++) begin
            irq_en[i] = intr_vec_i[i] & (mideleg_q[i] ? irq_s_ok : irq_m_ok);
        end
        irq_hit   = 1'b0;
        irq_cause = 4'd0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (irq_en[IRQ_PRIO[k]]) begin
                irq_hit   = 1'b1;
                irq_cause = 4'(IRQ_PRIO[k]);
            end
        end

        take_intr   = inst_valid_i & irq_hit;
        take_trap   = inst_valid_i & (irq_hit | exc_hit);
        cause       = irq_hit ? irq_cause : exc_cause;
        to_s        = (take_intr ? mideleg_q[cause] : medeleg_q[cause]) & (priv_q != PRIV_M);
        tvec        = to_s ? stvec_q : mtvec_q;
        trap_target = {tvec[XLEN-1:2], 2'b00} +
                      (((tvec[1:0] == 2'b01) && take_intr) ? {58'b0, cause, 2'b00} : 64'd0);
        cause_word  = {take_intr, 59'b0, cause};
        ret_m       = do_mret & ~take_trap;
        ret_s       = do_sret & ~take_trap;

        ms_wr = (csr_wdata_i & MS_WMASK) | MS_XL;
        if (ms_wr[12:11] == 2'b10) begin
            ms_wr[12:11] = PRIV_U;
        end
    end

    always_comb begin
        priv_d            = priv_q;
        mstatus_d         = mstatus_q;
        mepc_d            = mepc_q;
        mcause_d          = mcause_q;
        sepc_d            = sepc_q;
        scause_d          = scause_q;
        mtvec_d           = mtvec_q;
        stvec_d           = stvec_q;
        medeleg_d         = medeleg_q;
        mideleg_d         = mideleg_q;
        redirect_valid_d  = 1'b0;
        redirect_target_d = redirect_target_q;

        if (take_trap) begin
            if (to_s) begin
                mstatus_d[MS_SPIE] = mstatus_q[MS_SIE];
                mstatus_d[MS_SIE]  = 1'b0;
                mstatus_d[MS_SPP]  = priv_q[0];
                priv_d             = PRIV_S;
                sepc_d             = pc_i;
                scause_d           = cause_word;
            end else begin
                mstatus_d[MS_MPIE]  = mstatus_q[MS_MIE];
                mstatus_d[MS_MIE]   = 1'b0;
                mstatus_d[12:11]    = priv_q;
                priv_d              = PRIV_M;
                mepc_d              = pc_i;
                mcause_d            = cause_word;
            end
            redirect_valid_d  = 1'b1;
            redirect_target_d = trap_target;
        end else if (ret_m) begin
            mstatus_d[MS_MIE]  = mstatus_q[MS_MPIE];
            mstatus_d[MS_MPIE] = 1'b1;
            mstatus_d[12:11]   = PRIV_U;
            priv_d             = mstatus_q[12:11];
            redirect_valid_d   = 1'b1;
            redirect_target_d  = mepc_q;
        end else if (ret_s) begin
            mstatus_d[MS_SIE]  = mstatus_q[MS_SPIE];
            mstatus_d[MS_SPIE] = 1'b1;
            mstatus_d[MS_SPP]  = 1'b0;
            priv_d             = {1'b0, mstatus_q[MS_SPP]};
            redirect_valid_d   = 1'b1;
            redirect_target_d  = sepc_q;
        end else if (inst_valid_i & csr_wen_i) begin
            case (csr_addr_i)
                A_MSTATUS: mstatus_d = ms_wr;
                A_MEDELEG: medeleg_d = csr_wdata_i;
                A_MIDELEG: mideleg_d = csr_wdata_i;
                A_MTVEC:   mtvec_d   = csr_wdata_i;
                A_MEPC:    mepc_d    = {csr_wdata_i[XLEN-1:2], 2'b00};
                A_MCAUSE:  mcause_d  = csr_wdata_i;
                A_STVEC:   stvec_d   = csr_wdata_i;
                A_SEPC:    sepc_d    = {csr_wdata_i[XLEN-1:2], 2'b00};
                A_SCAUSE:  scause_d  = csr_wdata_i;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            priv_q            <= PRIV_M;
            mstatus_q         <= '0;
            mepc_q            <= '0;
            mcause_q          <= '0;
            sepc_q            <= '0;
            scause_q          <= '0;
            mtvec_q           <= MTVEC_RST;
            stvec_q           <= '0;
            medeleg_q         <= '0;
            mideleg_q         <= '0;
            redirect_valid_q  <= 1'b0;
            redirect_target_q <= '0;
        end else begin
            priv_q            <= priv_d;
            mstatus_q         <= mstatus_d;
            mepc_q            <= mepc_d;
            mcause_q          <= mcause_d;
            sepc_q            <= sepc_d;
            scause_q          <= scause_d;
            mtvec_q           <= mtvec_d;
            stvec_q           <= stvec_d;
            medeleg_q         <= medeleg_d;
            mideleg_q         <= mideleg_d;
            redirect_valid_q  <= redirect_valid_d;
            redirect_target_q <= redirect_target_d;
        end
    end

    assign priv_mode_o       = priv_q;
    assign mstatus_o         = mstatus_q;
    assign mepc_o            = mepc_q;
    assign mcause_o          = mcause_q;
    assign sepc_o            = sepc_q;
    assign scause_o          = scause_q;
    assign mtvec_o           = mtvec_q;
    assign stvec_o           = stvec_q;
    assign medeleg_o         = medeleg_q;
    assign mideleg_o         = mideleg_q;
    assign raise_trap_o      = take_trap;
    assign raise_intr_o      = take_intr;
    assign cause_no_o        = take_trap ? {60'b0, cause} : '0;
    assign redirect_valid_o  = redirect_valid_q;
    assign redirect_target_o = redirect_target_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Bench for trap_csr_unit: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural model of the trap/return/CSR rules.
module tb_trap_csr_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        inst_valid;
    logic [63:0] pc;
    logic [15:0] exc_vec;
    logic [11:0] intr_vec;
    logic        mret, sret, csr_wen;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;

    logic [1:0]  priv_mode;
    logic [63:0] mstatus, mepc, mcause, sepc, scause, mtvec, stvec, medeleg, mideleg;
    logic        raise_trap, raise_intr, redirect_valid;
    logic [63:0] cause_no, redirect_target;

    trap_csr_unit dut (
        .clk(clk), .rst_n(rst_n), .inst_valid_i(inst_valid), .pc_i(pc),
        .exc_vec_i(exc_vec), .intr_vec_i(intr_vec), .mret_i(mret), .sret_i(sret),
        .csr_wen_i(csr_wen), .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
        .priv_mode_o(priv_mode), .mstatus_o(mstatus), .mepc_o(mepc), .mcause_o(mcause),
        .sepc_o(sepc), .scause_o(scause), .mtvec_o(mtvec), .stvec_o(stvec),
        .medeleg_o(medeleg), .mideleg_o(mideleg), .raise_trap_o(raise_trap),
        .raise_intr_o(raise_intr), .cause_no_o(cause_no),
        .redirect_valid_o(redirect_valid), .redirect_target_o(redirect_target)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0]  m_priv;
    logic [63:0] m_ms, m_mepc, m_mcause, m_sepc, m_scause, m_mtvec, m_stvec, m_medeleg, m_mideleg;
    logic        m_rv;
    logic [63:0] m_rt;
    bit          e_trap, e_intr;
    int          e_cause;

    task automatic model_reset();
        m_priv = 2'b11; m_ms = 0; m_mepc = 0; m_mcause = 0; m_sepc = 0; m_scause = 0;
        m_mtvec = 64'h8000_0000; m_stvec = 0; m_medeleg = 0; m_mideleg = 0;
        m_rv = 0; m_rt = 0;
    endtask

    function automatic bit irq_enabled(input int c);
        if (m_mideleg[c]) return (m_priv == 2'b00) || (m_priv == 2'b01 && m_ms[1]);
        return (m_priv != 2'b11) || m_ms[3];
    endfunction

    task automatic model_comb();
        int iorder[6]  = '{11, 3, 7, 9, 1, 5};
        int eorder[13] = '{3, 12, 1, 2, 8, 9, 11, 6, 4, 15, 13, 7, 5};
        bit illegal;
        logic [15:0] ex;
        illegal = (mret && m_priv != 2'b11) ||
                  (sret && !mret && (m_priv == 2'b00 || (m_priv == 2'b01 && m_ms[22])));
        ex = exc_vec;
        if (illegal) ex[2] = 1'b1;
        e_trap = 0; e_intr = 0; e_cause = 0;
        if (inst_valid) begin
            foreach (iorder[k])
                if (!e_trap && intr_vec[iorder[k]] && irq_enabled(iorder[k])) begin
                    e_trap = 1; e_intr = 1; e_cause = iorder[k];
                end
            foreach (eorder[k])
                if (!e_trap && ex[eorder[k]]) begin
                    e_trap = 1; e_cause = eorder[k];
                end
        end
    endtask

    task automatic model_step();
        int wbits[13] = '{1, 3, 5, 7, 8, 11, 12, 17, 18, 19, 20, 21, 22};
        bit to_s;
        logic [63:0] tv, cw, nv;
        m_rv = 0;
        if (!inst_valid) return;
        if (e_trap) begin
            to_s = (e_intr ? m_mideleg[e_cause] : m_medeleg[e_cause]) && m_priv != 2'b11;
            tv = to_s ? m_stvec : m_mtvec;
            m_rt = (tv & ~64'h3) + ((tv[1:0] == 2'b01 && e_intr) ? 64'(4 * e_cause) : 64'd0);
            cw = (e_intr ? 64'h8000_0000_0000_0000 : 64'd0) | 64'(e_cause);
            if (to_s) begin
                m_ms[5] = m_ms[1]; m_ms[1] = 0; m_ms[8] = m_priv[0];
                m_sepc = pc; m_scause = cw; m_priv = 2'b01;
            end else begin
                m_ms[7] = m_ms[3]; m_ms[3] = 0; m_ms[12:11] = m_priv;
                m_mepc = pc; m_mcause = cw; m_priv = 2'b11;
            end
            m_rv = 1;
        end else if (mret) begin
            m_ms[3] = m_ms[7]; m_ms[7] = 1; m_priv = m_ms[12:11]; m_ms[12:11] = 0;
            m_rv = 1; m_rt = m_mepc;
        end else if (sret) begin
            m_ms[1] = m_ms[5]; m_ms[5] = 1; m_priv = {1'b0, m_ms[8]}; m_ms[8] = 0;
            m_rv = 1; m_rt = m_sepc;
        end else if (csr_wen) begin
            case (csr_addr)
                12'h300: begin
                    nv = 0;
                    foreach (wbits[k]) nv[wbits[k]] = csr_wdata[wbits[k]];
                    nv[33:32] = 2'd2; nv[35:34] = 2'd2;
                    if (nv[12:11] == 2'b10) nv[12:11] = 2'b00;
                    m_ms = nv;
                end
                12'h302: m_medeleg = csr_wdata;
                12'h303: m_mideleg = csr_wdata;
                12'h305: m_mtvec   = csr_wdata;
                12'h341: m_mepc    = csr_wdata & ~64'h3;
                12'h342: m_mcause  = csr_wdata;
                12'h105: m_stvec   = csr_wdata;
                12'h141: m_sepc    = csr_wdata & ~64'h3;
                12'h142: m_scause  = csr_wdata;
                default: ;
            endcase
        end
    endtask

    // Compare process: mid-cycle, inputs stable since just after the previous rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            model_comb();
            chk("raise_trap", 64'(raise_trap), 64'(e_trap));
            chk("raise_intr", 64'(raise_intr), 64'(e_intr));
            chk("cause_no", cause_no, e_trap ? 64'(e_cause) : 64'd0);
            chk("priv_mode", 64'(priv_mode), 64'(m_priv));
            chk("mstatus", mstatus, m_ms);
            chk("mepc", mepc, m_mepc);
            chk("mcause", mcause, m_mcause);
            chk("sepc", sepc, m_sepc);
            chk("scause", scause, m_scause);
            chk("mtvec", mtvec, m_mtvec);
            chk("stvec", stvec, m_stvec);
            chk("medeleg", medeleg, m_medeleg);
            chk("mideleg", mideleg, m_mideleg);
            chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
            chk("redirect_target", redirect_target, m_rt);
            if (rst_n) model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [63:0] p, input logic [15:0] e,
                         input logic [11:0] i, input logic mr, input logic sr,
                         input logic w, input logic [11:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        inst_valid = v; pc = p; exc_vec = e; intr_vec = i;
        mret = mr; sret = sr; csr_wen = w; csr_addr = a; csr_wdata = d;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        drive(1, 64'h100, 0, 0, 0, 0, 1, a, d);
    endtask

    initial begin
        logic [11:0] addrs[10] = '{12'h300, 12'h302, 12'h303, 12'h305, 12'h341,
                                   12'h342, 12'h105, 12'h141, 12'h142, 12'h340};
        logic [15:0] e;
        logic [11:0] iv;
        rst_n = 0;
        inst_valid = 0; pc = 0; exc_vec = 0; intr_vec = 0;
        mret = 0; sret = 0; csr_wen = 0; csr_addr = 0; csr_wdata = 0;
        repeat (3) idle();
        chk("rst priv", 64'(priv_mode), 64'h3);
        chk("rst mstatus", mstatus, 64'h0);
        chk("rst mtvec", mtvec, 64'h8000_0000);
        chk("rst redirect_valid", 64'(redirect_valid), 64'h0);
        rst_n = 1;

        // illegal-instruction exception taken in M
        drive(1, 64'h8000_0100, 16'h0004, 0, 0, 0, 0, 0, 0);
        #2;
        chk("t1 raise_trap", 64'(raise_trap), 64'h1);
        chk("t1 cause_no", cause_no, 64'h2);
        idle();
        chk("t1 mcause", mcause, 64'h2);
        chk("t1 mepc", mepc, 64'h8000_0100);
        chk("t1 redirect_valid", 64'(redirect_valid), 64'h1);
        chk("t1 redirect_target", redirect_target, 64'h8000_0000);
        chk("t1 priv", 64'(priv_mode), 64'h3);
        chk("t1 mstatus", mstatus, 64'h1800);
        idle();
        chk("t1 pulse ends", 64'(redirect_valid), 64'h0);

        // drop to U, then a delegated ecall-from-U goes to S
        wr(12'h300, 64'h2);
        wr(12'h302, 64'h100);
        wr(12'h341, 64'h4000);
        drive(1, 64'h200, 0, 0, 1, 0, 0, 0, 0);
        idle();
        chk("t2 mret priv", 64'(priv_mode), 64'h0);
        chk("t2 mret target", redirect_target, 64'h4000);
        chk("t2 mret mstatus", mstatus, 64'hA_0000_0082);
        drive(1, 64'h4010, 16'h0100, 0, 0, 0, 0, 0, 0);
        #2;
        chk("t2 cause_no", cause_no, 64'h8);
        idle();
        chk("t2 priv", 64'(priv_mode), 64'h1);
        chk("t2 scause", scause, 64'h8);
        chk("t2 sepc", sepc, 64'h4010);
        chk("t2 mepc kept", mepc, 64'h4000);
        chk("t2 mstatus", mstatus, 64'hA_0000_00A0);

        // exception priority
        drive(1, 64'h300, 16'h100C, 0, 0, 0, 0, 0, 0);
        #2; chk("t3 cause 3", cause_no, 64'd3);
        drive(1, 64'h304, 16'h1002, 0, 0, 0, 0, 0, 0);
        #2; chk("t3 cause 12", cause_no, 64'd12);
        drive(1, 64'h308, 16'h0006, 0, 0, 0, 0, 0, 0);
        #2; chk("t3 cause 1", cause_no, 64'd1);

        // interrupt beats exception, vectored mtvec
        wr(12'h300, 64'h8);
        wr(12'h305, 64'h8000_0001);
        drive(1, 64'h700, 16'h0004, 12'h080, 0, 0, 0, 0, 0);
        #2;
        chk("t4 raise_intr", 64'(raise_intr), 64'h1);
        chk("t4 cause_no", cause_no, 64'h7);
        idle();
        chk("t4 mcause", mcause, 64'h8000_0000_0000_0007);
        chk("t4 target", redirect_target, 64'h8000_001C);

        // legal MRET to S, then MRET in S is illegal
        wr(12'h300, 64'h880);
        wr(12'h341, 64'h8000_2000);
        drive(1, 64'h800, 0, 0, 1, 0, 0, 0, 0);
        idle();
        chk("t5 priv", 64'(priv_mode), 64'h1);
        chk("t5 mstatus", mstatus, 64'hA_0000_0088);
        chk("t5 target", redirect_target, 64'h8000_2000);
        drive(1, 64'h900, 0, 0, 1, 0, 0, 0, 0);
        #2;
        chk("t5 illegal trap", 64'(raise_trap), 64'h1);
        chk("t5 illegal cause", cause_no, 64'h2);
        idle();
        chk("t5 illegal priv", 64'(priv_mode), 64'h3);
        chk("t5 illegal mepc", mepc, 64'h900);
        chk("t5 illegal target", redirect_target, 64'h8000_0000);

        // CSR write dropped under a trap; alignment of mepc
        drive(1, 64'h5000, 16'h0004, 0, 0, 0, 1, 12'h341, 64'h1234);
        idle();
        chk("t6 dropped write", mepc, 64'h5000);
        wr(12'h341, 64'h1003);
        idle();
        chk("t6 mepc align", mepc, 64'h1000);

        // inst_valid low masks everything
        drive(0, 64'h6000, 16'h0004, 0, 0, 0, 1, 12'h341, 64'hFFFF_0000);
        #2; chk("t7 no trap", 64'(raise_trap), 64'h0);
        idle();
        chk("t7 mepc", mepc, 64'h1000);
        chk("t7 no redirect", 64'(redirect_valid), 64'h0);

        // MPP=10 is not a legal mode
        wr(12'h300, 64'h1000);
        idle();
        chk("t8 mpp map", mstatus, 64'hA_0000_0000);

        // random traffic, with one reset mid-stream
        for (int n = 0; n < 3000; n++) begin
            e = 0;
            if ($urandom_range(0, 3) == 0) e = 16'(1 << $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) e = e | 16'(1 << $urandom_range(0, 15));
            iv = ($urandom_range(0, 3) == 0) ? (12'($urandom) & 12'($urandom)) : 12'h0;
            drive($urandom_range(0, 9) != 0, {$urandom, $urandom}, e, iv,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0, addrs[$urandom_range(0, 9)],
                  {$urandom, $urandom});
            if (n == 1500) begin
                rst_n = 0;
                #2;
                chk("mid reset redirect", 64'(redirect_valid), 64'h0);
                chk("mid reset priv", 64'(priv_mode), 64'h3);
            end else if (n == 1501) begin
                rst_n = 1;
            end
        end
        idle();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
- Machine/supervisor trap-entry and trap-return sequencer for the 64-bit core.
- Sits between the commit-stage exception/interrupt collection and the CSR state consumed by the CSR assertion checker.
- Each cycle it resolves the highest-priority interrupt or exception and applies M/S delegation.
- It updates mstatus, mepc/mcause, sepc/scause and the privilege mode, then issues a registered PC redirect.

Parameters:
XLEN, 64, data/address width; only 64 is supported, elaboration error otherwise
EXC_W, 16, width of the exception-cause vector
MTVEC_RST, 64'h8000_0000, reset value of mtvec

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst_valid  in  1  committing instruction is valid; all events are qualified by it
pc  in  XLEN  PC of the committing instruction
exc_vec  in  EXC_W  raised exception bits, indexed by cause number
intr_vec  in  12  pending interrupts (mip & mie), indexed by cause number
mret  in  1  MRET committing
sret  in  1  SRET committing
csr_wen  in  1  CSR write strobe
csr_addr  in  12  CSR address (mstatus 0x300, medeleg 0x302, mideleg 0x303, mtvec 0x305, mepc 0x341, mcause 0x342, stvec 0x105, sepc 0x141, scause 0x142)
csr_wdata  in  XLEN  CSR write data
priv_mode  out  2  current privilege (U=00, S=01, M=11)
mstatus  out  XLEN  mstatus register
mepc, mcause, sepc, scause, mtvec, stvec, medeleg, mideleg  out  XLEN each  CSR registers
raise_trap  out  1  combinational: a trap is taken this cycle
raise_intr  out  1  combinational: the trap is an interrupt
cause_no  out  XLEN  combinational: selected cause number, zero-extended
redirect_valid  out  1  registered, one-cycle pulse
redirect_target  out  XLEN  registered redirect PC

Behaviour:
- Reset values (async assert, sync release):
  - priv_mode=11.
  - mstatus, mepc, mcause, sepc, scause, stvec, medeleg, mideleg = 0; mtvec=MTVEC_RST.
  - redirect_valid=0, redirect_target=0.
- Interrupt enable:
  - Non-delegated (mideleg[i]=0): enabled if priv<M or mstatus.MIE.
  - Delegated: enabled if priv<S, or priv==S and SIE. Never taken in M.
- Interrupt priority: 11 > 3 > 7 > 9 > 1 > 5.
- Exception priority: 3 > 12 > 1 > 2 > 8/9/11 > 6 > 4 > 15 > 13 > 7 > 5.
- Illegal returns: MRET with priv<M, or SRET with priv==U (or TSR=1 in S), raise cause 2 instead of returning.
- Trap selection: raise_trap = inst_valid & (any enabled interrupt | any exception). An enabled interrupt beats any exception.
- Delegation: deleg = raise_intr ? mideleg : medeleg. The trap goes to S iff deleg[cause_no[3:0]] && priv_mode!=M; otherwise to M.
- M-trap, applied at the next edge:
  - MPIE<=MIE, MIE<=0, MPP<=priv, priv<=M.
  - mepc<=pc, mcause<={raise_intr,cause}.
  - Target: mtvec base. If mtvec[1:0]==01 and interrupt: base+4*cause.
- S-trap, applied at the next edge:
  - SPIE<=SIE, SIE<=0, SPP<=priv[0], priv<=S.
  - sepc<=pc, scause<={raise_intr,cause}.
  - Target: stvec, using the same vectoring rule.
- MRET (legal): MIE<=MPIE, MPIE<=1, priv<=MPP, MPP<=U; target mepc.
- SRET (legal): SIE<=SPIE, SPIE<=1, priv<={0,SPP}, SPP<=0; target sepc.
- Redirect timing: every trap or legal return produces redirect_valid=1 in the cycle after the event, with redirect_target registered. redirect_valid is 0 otherwise.
- Event priority in one cycle: trap > return > CSR write. A CSR write in a trap or return cycle is dropped. mret and sret both asserted is treated as mret.
- CSR write rules:
  - mepc/sepc: bits[1:0]=0.
  - mstatus writable fields: SIE, MIE, SPIE, MPIE, SPP, MPP, MPRV, SUM, MXR, TVM, TW, TSR. Others read 0; UXL/SXL read 2.
  - MPP write of 10 maps to 00.
  - Writes to unlisted addresses are ignored.
- inst_valid=0: no state change; raise_trap=0.
- Reset mid-operation clears any pending redirect.

Test Plan:
- Reset, then pc=0x8000_0100, exc_vec bit 2 in M -> raise_trap=1, cause_no=2. Next cycle: mcause=2, mepc=0x8000_0100, redirect 0x8000_0000, priv=11.
- priv=U, medeleg[8]=1, exc_vec bit 8 -> S-trap. Next cycle: priv=01, scause=8, SPP=0, SIE=0, SPIE=old SIE; mepc unchanged.
- exc_vec bits 3,12,2 together -> cause 3. Then bits 12,1 -> cause 12. Then bits 1,2 -> cause 1.
- MIE=1, intr_vec bit 7 with exc_vec bit 2 -> raise_intr=1, mcause=0x8000_0000_0000_0007. With mtvec=0x8000_0001 -> target 0x8000_001C.
- MPP=01, MPIE=1, MRET in M, redirect 0x8000_2000 -> next cycle priv=01, MIE=1, MPIE=1, MPP=00. The same MRET in S -> cause 2 trap.
- csr_wen to mepc with a concurrent trap -> write dropped. Alone with 0x1003 -> mepc=0x1000.
